// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller, its shift register and the host consumer.
// master: controller side; slave: shift register / consumer side.
interface uart_rx_ctrl_if;
    logic       serial_in;
    logic [7:0] packet_data;
    logic       stop_bit;
    logic       data_read;
    logic       shift_strobe;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;
    logic       rx_busy;

    modport master (
        input  serial_in, packet_data, stop_bit, data_read,
        output shift_strobe, rx_data, data_ready, overrun_error, framing_error, rx_busy
    );

    modport slave (
        output serial_in, packet_data, stop_bit, data_read,
        input  shift_strobe, rx_data, data_ready, overrun_error, framing_error, rx_busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start-bit detection, mid-bit shift strobes for a 9-bit
// shift register, stop-bit check and host-side byte buffer with status flags.
module uart_rx_ctrl #(
    parameter int BIT_PERIOD = 10
) (
    input  logic           clk,
    input  logic           n_rst,
    uart_rx_ctrl_if.master bus
);
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = $clog2(BIT_PERIOD);

    typedef enum logic [1:0] {IDLE, START_CHK, RX_BITS, CHECK} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             data_ready_q, data_ready_d;
    logic             overrun_q, overrun_d;
    logic             framing_q, framing_d;
    logic             start_edge;
    logic             strobe;

    assign start_edge = prev_q & ~sync_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync_q       <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            framing_q    <= framing_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.serial_in;
        sync_d       = sync1_q;
        prev_d       = sync_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;
        framing_d    = framing_q;
        strobe       = 1'b0;

        // A load in CHECK takes priority over a coincident consumer acknowledge.
        if (bus.data_read && state_q != CHECK) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START_CHK;
                    cnt_d   = '0;
                end
            end
            START_CHK: begin
                if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
                    if (sync_q) begin
                        state_d = IDLE;
                    end else begin
                        framing_d = 1'b0;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = RX_BITS;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_BITS: begin
                if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
                    strobe    = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = CHECK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (bus.stop_bit) begin
                    rx_data_d    = bus.packet_data;
                    data_ready_d = 1'b1;
                    if (data_ready_q && !bus.data_read) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    framing_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.shift_strobe  = strobe;
    assign bus.rx_data       = rx_data_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.overrun_error = overrun_q;
    assign bus.framing_error = framing_q;
    assign bus.rx_busy       = (state_q != IDLE);
endmodule
